// File: rtl/hdmi_period_sequencer.sv
// hdmi_period_sequencer: chooses the TMDS period, control bits and packet timing for every pixel clock.
module hdmi_period_sequencer #(
  parameter int PRE_LEN  = 8,
  parameter int GB_LEN   = 2,
  parameter int PKT_LEN  = 32,
  parameter int MAX_PKTS = 18,
  parameter int CTL_MIN  = 12,
  parameter int CNT_W    = 12,
  parameter int DVI_MODE = 0
) (
  input  logic       I_CLK_PIXEL,
  input  logic       I_RESET_N,
  input  logic       I_DE,
  input  logic       I_PKT_VALID,
  output logic       O_PKT_START,
  output logic [4:0] O_PKT_IDX,
  output logic [2:0] O_PERIOD,
  output logic [3:0] O_CTL,
  output logic       O_ABORT
);
  typedef enum logic [2:0] {
    CTRL        = 3'b000,
    VID         = 3'b001,
    VID_PRE     = 3'b010,
    VID_GB      = 3'b011,
    DI_PRE      = 3'b100,
    DI_GB_LEAD  = 3'b101,
    DI_GB_TRAIL = 3'b110,
    DI_PKT      = 3'b111
  } state_t;
  localparam int NW = $clog2(MAX_PKTS + 1);
  localparam logic [CNT_W-1:0] SAT      = '1;
  localparam logic [CNT_W-1:0] ISL_NEED = CNT_W'(PRE_LEN + 2 * GB_LEN + PKT_LEN + CTL_MIN);
  localparam logic [CNT_W-1:0] PKT_NEED = CNT_W'(PKT_LEN + GB_LEN + CTL_MIN);
  localparam logic [CNT_W-1:0] CTL_NEED = CNT_W'(CTL_MIN);
  localparam logic [7:0] PRE_END = 8'(PRE_LEN - 1);
  localparam logic [7:0] GB_END  = 8'(GB_LEN - 1);
  localparam logic [4:0] PKT_END = 5'(PKT_LEN - 1);
  localparam logic [NW-1:0] PKT_MAX = NW'(MAX_PKTS);
  state_t state_q, state_d;
  logic de_q;
  logic [CNT_W-1:0] b_q, b_d, l_q, l_d, c_q, c_d;
  logic [CNT_W:0] rem;
  logic fits_isl, fits_pkt, in_vid;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] idx_q, idx_d;
  logic [NW-1:0] n_q, n_d;
  logic [2:0] period_q, period_d;
  logic [3:0] ctl_q, ctl_d;
  logic start_q, start_d, abort_q, abort_d;
  // Remaining blank is L - B; a borrow into the top bit means the line is already overdue.
  assign rem = {1'b0, l_q} - {1'b0, b_q};
  assign fits_isl = !rem[CNT_W] && rem[CNT_W-1:0] >= ISL_NEED;
  assign fits_pkt = !rem[CNT_W] && rem[CNT_W-1:0] >= PKT_NEED;
  assign in_vid = state_q == VID_PRE || state_q == VID_GB || state_q == VID;
  assign b_d = I_DE ? b_q : de_q ? '0 : b_q == SAT ? b_q : b_q + 1'b1;
  assign l_d = (I_DE && !de_q) ? b_q : l_q;
  // C restarts on every return to control so a trailing guard band also earns CTL_MIN clocks.
  assign c_d = state_q != CTRL ? '0 : c_q == SAT ? c_q : c_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    idx_d   = '0;
    n_d     = n_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    if (I_DE && !in_vid) begin
      state_d = VID_PRE;
      cnt_d   = '0;
      abort_d = state_q[2];
    end else begin
      case (state_q)
        CTRL: if (I_PKT_VALID && DVI_MODE == 0 && b_q >= CTL_NEED && c_q >= CTL_NEED && fits_isl) begin
          state_d = DI_PRE;
          cnt_d   = '0;
        end
        VID_PRE: if (cnt_q == PRE_END) begin
          state_d = VID_GB;
          cnt_d   = '0;
        end
        VID_GB: if (cnt_q == GB_END) state_d = VID;
        VID: if (!I_DE) state_d = CTRL;
        DI_PRE: if (cnt_q == PRE_END) begin
          state_d = DI_GB_LEAD;
          cnt_d   = '0;
        end
        DI_GB_LEAD: if (cnt_q == GB_END) begin
          state_d = DI_PKT;
          start_d = 1'b1;
          n_d     = NW'(1);
        end
        DI_PKT: begin
          idx_d = idx_q + 5'd1;
          if (idx_q == PKT_END) begin
            idx_d = '0;
            if (I_PKT_VALID && n_q < PKT_MAX && fits_pkt) begin
              start_d = 1'b1;
              n_d     = n_q + 1'b1;
            end else begin
              state_d = DI_GB_TRAIL;
              cnt_d   = '0;
            end
          end
        end
        DI_GB_TRAIL: if (cnt_q == GB_END) state_d = CTRL;
        default: state_d = CTRL;
      endcase
    end
  end
  // DVI keeps the video lead-in timing but shows it to the encoders as plain control.
  assign period_d = (DVI_MODE != 0 && (state_d == VID_PRE || state_d == VID_GB)) ? 3'b000 : state_d;
  assign ctl_d = state_d == DI_PRE ? 4'b0101 : (state_d == VID_PRE && DVI_MODE == 0) ? 4'b0001 : 4'b0000;
  always_ff @(posedge I_CLK_PIXEL) begin
    if (!I_RESET_N) begin
      state_q  <= CTRL;
      de_q     <= 1'b0;
      b_q      <= '0;
      l_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      period_q <= '0;
      ctl_q    <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      de_q     <= I_DE;
      b_q      <= b_d;
      l_q      <= l_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      period_q <= period_d;
      ctl_q    <= ctl_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
    end
  end
  assign O_PERIOD    = period_q;
  assign O_CTL       = ctl_q;
  assign O_PKT_START = start_q;
  assign O_PKT_IDX   = idx_q;
  assign O_ABORT     = abort_q;
endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// tb_hdmi_period_sequencer: directed line/blank sequences with a queue of expected per-clock outputs for an HDMI and a DVI instance.
module tb_hdmi_period_sequencer;
  localparam logic [2:0] P_CTRL = 3'b000, P_VID = 3'b001, P_VPRE = 3'b010, P_VGB = 3'b011;
  localparam logic [2:0] P_DPRE = 3'b100, P_LEAD = 3'b101, P_TRAIL = 3'b110, P_PKT = 3'b111;
  typedef struct packed {
    logic [2:0] per;
    logic [3:0] ctl;
    logic       st;
    logic       ab;
    logic [4:0] idx;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, de, pv;
  logic h_st, h_ab, d_st, d_ab;
  logic [4:0] h_idx, d_idx;
  logic [2:0] h_per, d_per;
  logic [3:0] h_ctl, d_ctl;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  always #5 clk = ~clk;
  hdmi_period_sequencer dut_h (
    .I_CLK_PIXEL(clk), .I_RESET_N(rst_n), .I_DE(de), .I_PKT_VALID(pv),
    .O_PKT_START(h_st), .O_PKT_IDX(h_idx), .O_PERIOD(h_per), .O_CTL(h_ctl), .O_ABORT(h_ab)
  );
  hdmi_period_sequencer #(.DVI_MODE(1)) dut_d (
    .I_CLK_PIXEL(clk), .I_RESET_N(rst_n), .I_DE(de), .I_PKT_VALID(pv),
    .O_PKT_START(d_st), .O_PKT_IDX(d_idx), .O_PERIOD(d_per), .O_CTL(d_ctl), .O_ABORT(d_ab)
  );
  function automatic string show(input exp_t v);
    return $sformatf("per=%0d ctl=%b st=%b ab=%b idx=%0d", v.per, v.ctl, v.st, v.ab, v.idx);
  endfunction
  task automatic push(input int n, input logic [2:0] per, input logic [3:0] ctl);
    for (int i = 0; i < n; i++) exp_q.push_back('{per: per, ctl: ctl, st: 1'b0, ab: 1'b0, idx: 5'd0});
  endtask
  task automatic push_pkt(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{per: P_PKT, ctl: 4'd0, st: (i == 0), ab: 1'b0, idx: 5'(i)});
  endtask
  task automatic push_line(input int n, input logic ab);
    exp_q.push_back('{per: P_VPRE, ctl: 4'b0001, st: 1'b0, ab: ab, idx: 5'd0});
    push(7, P_VPRE, 4'b0001);
    push(2, P_VGB, 4'b0000);
    push(n - 10, P_VID, 4'b0000);
  endtask
  task automatic push_island_head();
    push(13, P_CTRL, 4'b0000);
    push(8, P_DPRE, 4'b0101);
    push(2, P_LEAD, 4'b0000);
  endtask
  task automatic cyc(input logic r, input logic d, input logic p);
    exp_t e, ed, gh, gd;
    rst_n = r;
    de = d;
    pv = p;
    @(posedge clk);
    #1;
    cyc_n++;
    gh = '{per: h_per, ctl: h_ctl, st: h_st, ab: h_ab, idx: h_idx};
    gd = '{per: d_per, ctl: d_ctl, st: d_st, ab: d_ab, idx: d_idx};
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow cyc=%0d got=empty exp=entry", cyc_n);
    end else begin
      e = exp_q.pop_front();
      ed = '{per: (e.per == P_VID) ? P_VID : P_CTRL, ctl: 4'd0, st: 1'b0, ab: 1'b0, idx: 5'd0};
      checks++;
      assert (gh === e) else begin
        errors++;
        $error("FAIL hdmi cyc=%0d got %s exp %s", cyc_n, show(gh), show(e));
      end
      checks++;
      assert (gd === ed) else begin
        errors++;
        $error("FAIL dvi cyc=%0d got %s exp %s", cyc_n, show(gd), show(ed));
      end
    end
  endtask
  task automatic run(input int n, input logic r, input logic d, input logic p);
    for (int i = 0; i < n; i++) cyc(r, d, p);
  endtask
  initial begin
    rst_n = 1'b0;
    de = 1'b0;
    pv = 1'b0;
    push(2, P_CTRL, 4'b0000);
    run(2, 1'b0, 1'b0, 1'b0);
    // Video only: 200 blank then 640 active, no packets.
    push(200, P_CTRL, 4'b0000);
    run(200, 1'b1, 1'b0, 1'b0);
    push_line(640, 1'b0);
    run(640, 1'b1, 1'b1, 1'b0);
    // Single packet island in a 200-clock blank; valid drops once the packet has started.
    push_island_head();
    push_pkt(32);
    push(2, P_TRAIL, 4'b0000);
    push(143, P_CTRL, 4'b0000);
    run(24, 1'b1, 1'b0, 1'b1);
    run(176, 1'b1, 1'b0, 1'b0);
    push_line(50, 1'b0);
    run(50, 1'b1, 1'b1, 1'b0);
    // Learn a 120-clock blank, then hold valid: budget allows exactly two packets.
    push(121, P_CTRL, 4'b0000);
    run(121, 1'b1, 1'b0, 1'b0);
    push_line(50, 1'b0);
    run(50, 1'b1, 1'b1, 1'b0);
    push_island_head();
    push_pkt(32);
    push_pkt(32);
    push(2, P_TRAIL, 4'b0000);
    push(32, P_CTRL, 4'b0000);
    run(121, 1'b1, 1'b0, 1'b1);
    push_line(50, 1'b0);
    run(50, 1'b1, 1'b1, 1'b0);
    // Learn a 200-clock blank, then cut the next blank to 40 mid-packet.
    push(201, P_CTRL, 4'b0000);
    run(201, 1'b1, 1'b0, 1'b0);
    push_line(50, 1'b0);
    run(50, 1'b1, 1'b1, 1'b0);
    push_island_head();
    push_pkt(17);
    run(40, 1'b1, 1'b0, 1'b1);
    push_line(50, 1'b1);
    run(50, 1'b1, 1'b1, 1'b0);
    // Reset in the middle of a packet; afterwards the learned blank is zero so nothing is admitted.
    push(201, P_CTRL, 4'b0000);
    run(201, 1'b1, 1'b0, 1'b0);
    push_line(50, 1'b0);
    run(50, 1'b1, 1'b1, 1'b0);
    push_island_head();
    push_pkt(6);
    run(29, 1'b1, 1'b0, 1'b1);
    push(1, P_CTRL, 4'b0000);
    run(1, 1'b0, 1'b0, 1'b1);
    push(100, P_CTRL, 4'b0000);
    run(100, 1'b1, 1'b0, 1'b1);
    push_line(20, 1'b0);
    run(20, 1'b1, 1'b1, 1'b1);
    push(1, P_CTRL, 4'b0000);
    run(1, 1'b1, 1'b0, 1'b0);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
